// File: rtl/board_io_adapter.sv
// Board-side I/O stage: button synchronise/debounce with press pulses, colour
// depth reduction with optional 2x2 ordered dither, and 1-cycle sync alignment.

module board_io_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic btn,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   btn_q, btn_d;
  logic                   press_q, press_d;
  logic                   s;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    s       = sync_q[SYNC_STAGES-1];
    btn_d   = btn_q;
    cnt_d   = '0;
    if (s != btn_q) begin
      // Accept the new level only after DEBOUNCE_CYCLES consecutive mismatches
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) btn_d = s;
      else                                   cnt_d = cnt_q + 1'b1;
    end
    press_d = btn_d & ~btn_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      press_q <= press_d;
    end
  end

  assign btn   = btn_q;
  assign press = press_q;
endmodule

module board_io_adapter #(
  parameter int N_BTN           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int IN_BITS         = 8,
  parameter int OUT_BITS        = 4,
  parameter int DITHER          = 1,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                CLK_25MHZ,
  input  logic                RESET,
  input  logic [N_BTN-1:0]    BTN_RAW,
  output logic [N_BTN-1:0]    BTN,
  output logic [N_BTN-1:0]    BTN_PRESS,
  input  logic                HSYNC_IN,
  input  logic                VSYNC_IN,
  input  logic [IN_BITS-1:0]  RED_IN,
  input  logic [IN_BITS-1:0]  GREEN_IN,
  input  logic [IN_BITS-1:0]  BLUE_IN,
  output logic                HSYNC_OUT,
  output logic                VSYNC_OUT,
  output logic [OUT_BITS-1:0] RED_OUT,
  output logic [OUT_BITS-1:0] GREEN_OUT,
  output logic [OUT_BITS-1:0] BLUE_OUT
);
  localparam int   D         = IN_BITS - OUT_BITS;
  localparam bit   DITHER_EN = (DITHER != 0) && (D >= 2);
  localparam int   TSH       = DITHER_EN ? D - 2 : 0;
  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

  board_io_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb [N_BTN-1:0] (
    .clk  (CLK_25MHZ),
    .rst  (RESET),
    .raw  (BTN_RAW),
    .btn  (BTN),
    .press(BTN_PRESS)
  );

  logic                xp_q, xp_d, yp_q, yp_d, hs_prev_q, hs_prev_d;
  logic                hs_q, vs_q;
  logic [OUT_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                hs_act, vs_act;
  logic [1:0]          bayer;
  logic [IN_BITS:0]    thr;

  // Sum is one bit wider than the input so full scale plus threshold saturates
  function automatic logic [OUT_BITS-1:0] reduce(input logic [IN_BITS-1:0] c,
                                                 input logic [IN_BITS:0]   t);
    logic [IN_BITS:0]  sum;
    logic [OUT_BITS:0] q;
    if (DITHER_EN) begin
      sum    = {1'b0, c} + t;
      q      = (OUT_BITS+1)'(sum >> D);
      reduce = q[OUT_BITS] ? '1 : q[OUT_BITS-1:0];
    end else begin
      reduce = OUT_BITS'(c >> D);
    end
  endfunction

  always_comb begin
    hs_act    = HSYNC_IN ^ SYNC_IDLE;
    vs_act    = VSYNC_IN ^ SYNC_IDLE;
    xp_d      = hs_act ? 1'b0 : ~xp_q;
    yp_d      = yp_q;
    if (vs_act)                   yp_d = 1'b0;
    else if (hs_act && !hs_prev_q) yp_d = ~yp_q;
    hs_prev_d = hs_act;
    unique case ({yp_q, xp_q})
      2'b00:   bayer = 2'd0;
      2'b01:   bayer = 2'd2;
      2'b10:   bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
    thr = (IN_BITS+1)'(bayer) << TSH;
    r_d = reduce(RED_IN,   thr);
    g_d = reduce(GREEN_IN, thr);
    b_d = reduce(BLUE_IN,  thr);
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      xp_q      <= 1'b0;
      yp_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      hs_q      <= SYNC_IDLE;
      vs_q      <= SYNC_IDLE;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      xp_q      <= xp_d;
      yp_q      <= yp_d;
      hs_prev_q <= hs_prev_d;
      hs_q      <= HSYNC_IN;
      vs_q      <= VSYNC_IN;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign HSYNC_OUT = hs_q;
  assign VSYNC_OUT = vs_q;
  assign RED_OUT   = r_q;
  assign GREEN_OUT = g_q;
  assign BLUE_OUT  = b_q;
endmodule

// File: tb/tb_board_io_adapter.sv
// Bench for board_io_adapter: directed scenarios plus random traffic against a
// pixel-counter / run-length reference model.

module tb_board_io_adapter;
  localparam int N   = 2;
  localparam int SS  = 2;
  localparam int DEB = 4;
  localparam int IB  = 8;
  localparam int OB  = 4;
  localparam int D   = IB - OB;
  localparam int TSTEP = 1 << (D - 2);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw = '0;
  logic         hs_in = 1'b1, vs_in = 1'b1;
  logic [IB-1:0] r_in = '0, g_in = '0, b_in = '0;

  logic [N-1:0]  btn, press, t_btn, t_press;
  logic          hs_o, vs_o, t_hs, t_vs;
  logic [OB-1:0] r_o, g_o, b_o, t_r, t_g, t_b;

  int n_vec = 0, n_err = 0;

  always #20 clk = ~clk;

  board_io_adapter #(.N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB),
    .IN_BITS(IB), .OUT_BITS(OB), .DITHER(1), .SYNC_ACTIVE_LOW(1'b1)) u_dut (
    .CLK_25MHZ(clk), .RESET(rst), .BTN_RAW(raw), .BTN(btn), .BTN_PRESS(press),
    .HSYNC_IN(hs_in), .VSYNC_IN(vs_in), .RED_IN(r_in), .GREEN_IN(g_in), .BLUE_IN(b_in),
    .HSYNC_OUT(hs_o), .VSYNC_OUT(vs_o), .RED_OUT(r_o), .GREEN_OUT(g_o), .BLUE_OUT(b_o));

  board_io_adapter #(.N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB),
    .IN_BITS(IB), .OUT_BITS(OB), .DITHER(0), .SYNC_ACTIVE_LOW(1'b1)) u_trunc (
    .CLK_25MHZ(clk), .RESET(rst), .BTN_RAW(raw), .BTN(t_btn), .BTN_PRESS(t_press),
    .HSYNC_IN(hs_in), .VSYNC_IN(vs_in), .RED_IN(r_in), .GREEN_IN(g_in), .BLUE_IN(b_in),
    .HSYNC_OUT(t_hs), .VSYNC_OUT(t_vs), .RED_OUT(t_r), .GREEN_OUT(t_g), .BLUE_OUT(t_b));

  // reference model state
  int           pix, line;
  bit           prev_hs;
  logic [N-1:0] sh0, sh1, m_btn, m_press;
  int           run [N];
  logic [11:0]  m_rgb, m_trgb;
  logic [1:0]   m_sync;
  int           bayer_tab [4] = '{0, 2, 3, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] dith(input int c, input int b);
    int v;
    v = (c + b * TSTEP) >> D;
    return 4'(v > 15 ? 15 : v);
  endfunction

  task automatic model_step();
    int b;
    bit hs_a, vs_a;
    logic [N-1:0] np;
    if (rst) begin
      pix = 0; line = 0; prev_hs = 0;
      sh0 = '0; sh1 = '0; m_btn = '0; m_press = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
      m_rgb = '0; m_trgb = '0; m_sync = 2'b11;
    end else begin
      b      = bayer_tab[(line % 2) * 2 + (pix % 2)];
      m_rgb  = {dith(int'(r_in), b), dith(int'(g_in), b), dith(int'(b_in), b)};
      m_trgb = {r_in[7:4], g_in[7:4], b_in[7:4]};
      m_sync = {hs_in, vs_in};
      hs_a = !hs_in;
      vs_a = !vs_in;
      if (vs_a) line = 0;
      else if (hs_a && !prev_hs) line++;
      pix = hs_a ? 0 : pix + 1;
      prev_hs = hs_a;
      np = '0;
      for (int i = 0; i < N; i++) begin
        if (sh1[i] != m_btn[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            m_btn[i] = sh1[i];
            run[i]   = 0;
            np[i]    = sh1[i];
          end
        end else run[i] = 0;
      end
      m_press = np;
      sh1 = sh0;
      sh0 = raw;
    end
  endtask

  task automatic cyc(input logic rr, input logic [N-1:0] bt, input logic h, input logic v,
                     input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
    @(negedge clk);
    rst = rr; raw = bt; hs_in = h; vs_in = v; r_in = cr; g_in = cg; b_in = cb;
    model_step();
    @(posedge clk);
    #1;
    chk("btn",   32'(btn),   32'(m_btn));
    chk("press", 32'(press), 32'(m_press));
    chk("rgb",   32'({r_o, g_o, b_o}), 32'(m_rgb));
    chk("sync",  32'({hs_o, vs_o}),    32'(m_sync));
    chk("trgb",  32'({t_r, t_g, t_b}), 32'(m_trgb));
    chk("tsync", 32'({t_hs, t_vs}),    32'(m_sync));
  endtask

  task automatic wait_btn(input string tag);
    int lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      cyc(0, 2'b01, 1, 1, 8'h10, 8'h20, 8'h30);
      if (btn[0]) begin
        lat = k;
        chk({tag, "_press"}, 32'(press), 32'h1);
        chk({tag, "_btn1"},  32'(btn[1]), 32'h0);
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(SS + DEB));
    cyc(0, 2'b01, 1, 1, 8'h10, 8'h20, 8'h30);
    chk({tag, "_pulse1"}, 32'(press), 32'h0);
  endtask

  initial begin
    logic [N-1:0] rb;
    logic [7:0]   c [3];

    for (int i = 0; i < 3; i++)
      cyc(1, 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    chk("rst_rgb",  32'({r_o, g_o, b_o}), 32'h0);
    chk("rst_sync", 32'({hs_o, vs_o}),    32'h3);
    chk("rst_btn",  32'({btn, press}),    32'h0);

    // glitch of 3 cycles must be rejected
    for (int i = 0; i < 3; i++) cyc(0, 2'b01, 1, 1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 2'b00, 1, 1, 8'h00, 8'h00, 8'h00);
      chk("glitch_btn", 32'(btn), 32'h0);
    end
    wait_btn("deb");

    // reset with the button still held
    cyc(1, 2'b01, 1, 1, 8'h10, 8'h20, 8'h30);
    chk("midrst_btn", 32'(btn), 32'h0);
    wait_btn("redeb");

    // plain truncation and sync delay
    cyc(0, 2'b00, 0, 1, 8'hA7, 8'hFF, 8'h0F);
    chk("trunc", 32'({t_r, t_g, t_b}), 32'h0AF0);
    chk("hs_dly0", 32'(t_hs), 32'h0);
    cyc(0, 2'b00, 1, 1, 8'hA7, 8'hFF, 8'h0F);
    chk("hs_dly1", 32'(t_hs), 32'h1);

    // 2x2 dither block from a fresh parity origin
    cyc(1, 2'b00, 1, 1, 8'h08, 8'hFF, 8'h00);
    cyc(0, 2'b00, 1, 1, 8'h08, 8'hFF, 8'h00);
    chk("dith_00", 32'(r_o), 32'h0);
    cyc(0, 2'b00, 1, 1, 8'h08, 8'hFF, 8'h00);
    chk("dith_10", 32'(r_o), 32'h1);
    cyc(0, 2'b00, 0, 1, 8'h08, 8'hFF, 8'h00);
    cyc(0, 2'b00, 1, 1, 8'h08, 8'hFF, 8'h00);
    chk("dith_01", 32'(r_o), 32'h1);
    chk("sat_ff",  32'(g_o), 32'hF);
    cyc(0, 2'b00, 1, 1, 8'h08, 8'hFF, 8'h00);
    chk("dith_11", 32'(r_o), 32'h0);

    // hsync edge coincident with active vsync
    cyc(0, 2'b00, 0, 0, 8'h08, 8'h08, 8'h08);
    cyc(0, 2'b00, 1, 1, 8'h08, 8'h08, 8'h08);
    chk("vs_prio", 32'(r_o), 32'h0);

    rb = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) rb[i] = ~rb[i];
      for (int j = 0; j < 3; j++)
        case ($urandom_range(3))
          0:       c[j] = 8'hFF;
          1:       c[j] = 8'h00;
          default: c[j] = 8'($urandom);
        endcase
      cyc($urandom_range(299) == 0, rb, $urandom_range(9) != 0, $urandom_range(39) != 0,
          c[0], c[1], c[2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/board_io_adapter.md
Name: board_io_adapter

Overview:
- Registered board-side I/O stage between the board top level and topEntity, generalising the fixed 8-to-4-bit colour truncation and raw single-button wiring.
- Provides N_BTN button synchronisers and debouncers with press pulses.
- Reduces colour depth from IN_BITS to OUT_BITS per channel, with optional 2x2 ordered (Bayer) dithering.
- Delays HSYNC/VSYNC so they stay aligned with the colour outputs.
- Sits in the 25 MHz pixel clock domain.

Parameters:
- N_BTN, 1, number of button inputs.
- SYNC_STAGES, 2, synchroniser flops per button, ≥2.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a new button level (10 ms at 25 MHz), ≥1.
- IN_BITS, 8, input colour bits per channel.
- OUT_BITS, 4, output colour bits per channel, ≤IN_BITS.
- DITHER, 1, 1 = Bayer dither, 0 = plain truncation; DITHER=1 requires IN_BITS−OUT_BITS ≥ 2.
- SYNC_ACTIVE_LOW, 1, polarity of HSYNC/VSYNC pulses.

Ports:
- CLK_25MHZ  in  1  pixel clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- BTN_RAW  in  N_BTN  asynchronous raw buttons, active-high.
- BTN  out  N_BTN  debounced button level.
- BTN_PRESS  out  N_BTN  one-cycle pulse on each debounced 0→1 transition.
- HSYNC_IN  in  1  horizontal sync from topEntity.
- VSYNC_IN  in  1  vertical sync from topEntity.
- RED_IN, GREEN_IN, BLUE_IN  in  IN_BITS each  full-depth colour.
- HSYNC_OUT, VSYNC_OUT  out  1  syncs delayed 1 cycle.
- RED_OUT, GREEN_OUT, BLUE_OUT  out  OUT_BITS each  reduced colour.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, and clears all state in the cycle it is sampled.
- Reset values:
  - BTN=0, BTN_PRESS=0, colour outputs=0.
  - HSYNC_OUT/VSYNC_OUT = inactive level (1 if SYNC_ACTIVE_LOW, else 0).
  - Synchroniser flops=0, debounce counters=0, parity bits=0.
- Buttons, per bit, independent:
  - BTN_RAW passes through a SYNC_STAGES flop chain to give s.
  - If s==BTN, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES−1 while s≠BTN, BTN takes s on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes BTN.
  - BTN_PRESS is high for exactly the cycle after BTN goes 0→1. No pulse on 1→0.
  - Latency from a clean BTN_RAW edge to BTN change = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Pixel position parity (DITHER=1 only):
  - Sync "active" means equal to the active level.
  - xp toggles every cycle and clears on the cycle HSYNC_IN is active.
  - yp toggles on each HSYNC_IN inactive→active edge and clears while VSYNC_IN is active.
- Colour reduction, D = IN_BITS−OUT_BITS:
  - D=0: passthrough, registered.
  - DITHER=0: out = in[IN_BITS−1:D].
  - DITHER=1: Bayer index b = {0,2,3,1} for (yp,xp) = (0,0),(0,1),(1,0),(1,1). Threshold t = b·2^(D−2).
  - DITHER=1 result: sum = in + t, computed with IN_BITS+1 width; out = sum>>D, saturated to 2^OUT_BITS−1.
  - The same t applies to all three channels.
- Latency and alignment:
  - Colour and sync outputs are registered, with exactly 1 cycle latency, mutually aligned.
  - Sync polarity is passed through unchanged.
- Boundaries:
  - Full-scale input never wraps: it saturates.
  - Simultaneous hsync edge and vsync active: yp clears, because vsync has priority.
  - Reset mid-press: BTN returns to 0 and a held button re-qualifies after SYNC_STAGES + DEBOUNCE_CYCLES cycles, producing a fresh BTN_PRESS.
  - Reset mid-frame: outputs go to reset values for one cycle, and parity restarts at 0.

Test Plan:
- Reset: RESET=1 for 3 cycles with arbitrary inputs -> colour outputs 0, HSYNC_OUT=VSYNC_OUT=1, BTN=0, BTN_PRESS=0.
- Debounce (DEBOUNCE_CYCLES=4, SYNC_STAGES=2): BTN_RAW[0] high 3 cycles then low -> BTN stays 0. Held high -> BTN=1 exactly 6 cycles after the edge, BTN_PRESS=1 for one cycle, BTN[1] unaffected.
- Truncation (DITHER=0): RED_IN=0xA7, GREEN_IN=0xFF, BLUE_IN=0x0F -> next cycle outputs 0xA, 0xF, 0x0. HSYNC_OUT equals HSYNC_IN delayed 1 cycle.
- Dither: RED_IN=0x08 constant over a 2x2 pixel block (t = 0,8,12,4) -> RED_OUT = 0,1,1,0 at (xp,yp) positions (0,0),(1,0),(0,1),(1,1).
- Saturation: RED_IN=0xFF with t=12 -> RED_OUT=0xF, no wrap to 0.
- Reset mid-press: button held and BTN=1, assert RESET 1 cycle -> BTN=0, then BTN=1 again after 6 cycles with a new BTN_PRESS pulse.
